// File: rtl/zintack_if.sv
// Z80 IM2 interrupt bus bundle: strobes, bus controls, requests and vector outputs.
interface zintack_if;
  logic       zpos;
  logic       zneg;
  logic       m1_n;
  logic       iorq_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       int_n;
  logic [7:0] vec;
  logic       vec_oe;
  logic [3:0] ack;
  logic       tmo;

  modport master (
    output zpos, zneg, m1_n, iorq_n, req, mask,
    input  int_n, vec, vec_oe, ack, tmo
  );

  modport slave (
    input  zpos, zneg, m1_n, iorq_n, req, mask,
    output int_n, vec, vec_oe, ack, tmo
  );
endinterface

// File: rtl/zintack.sv
// Four-source Z80 IM2 interrupt controller with fixed priority and vector drive.
// Optional INT timeout counter enabled by defining ZINTACK_TIMEOUT_EN.
module zintack #(
  parameter logic [7:0] VEC_BASE = 8'hF0,
  parameter logic [5:0] TMO_CYC  = 6'd32
) (
  input logic fclk,
  input logic rst,
  zintack_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    DRIVE  = 2'd2
  } st_e;

  st_e        st_q, st_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] idx_q, idx_d;
  logic       int_n_q, int_n_d;
  logic [7:0] vec_q, vec_d;
  logic       oe_q, oe_d;
  logic [3:0] ack_q, ack_d;
  logic       tmo_q, tmo_d;
  logic [3:0] clr;
  logic [3:0] elig;
  logic [1:0] win;
  logic       inta;
  logic       tmo_hit;

  assign elig = pend_q & bus.mask;
  assign inta = !bus.m1_n && !bus.iorq_n && bus.zneg;

  always_comb begin
    win = 2'd0;
    priority casez (elig)
      4'b???1: win = 2'd0;
      4'b??10: win = 2'd1;
      4'b?100: win = 2'd2;
      4'b1000: win = 2'd3;
      default: win = 2'd0;
    endcase
  end

`ifdef ZINTACK_TIMEOUT_EN
  logic [5:0] cnt_q, cnt_d;

  assign tmo_hit = (st_q == ASSERT) && bus.zpos
                && ((cnt_q + 6'd1) == TMO_CYC);

  // Restarts each time INT is raised so every assertion gets a full window
  always_comb begin
    cnt_d = cnt_q;
    if (st_q == IDLE && st_d == ASSERT)
      cnt_d = 6'd0;
    else if (st_q == ASSERT && bus.zpos)
      cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) cnt_q <= 6'd0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam logic [5:0] UNUSED_TMO = TMO_CYC;
  logic unused_zpos;
  assign unused_zpos = bus.zpos;
  assign tmo_hit     = 1'b0;
`endif

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      pend_q  <= 4'd0;
      idx_q   <= 2'd0;
      int_n_q <= 1'b1;
      vec_q   <= 8'd0;
      oe_q    <= 1'b0;
      ack_q   <= 4'd0;
      tmo_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      int_n_q <= int_n_d;
      vec_q   <= vec_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (|elig) st_d = ASSERT;
      ASSERT: begin
        if (elig == 4'd0) st_d = IDLE;
        else if (inta)    st_d = DRIVE;
        else if (tmo_hit) st_d = IDLE;
      end
      DRIVE:   if (bus.iorq_n) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    int_n_d = int_n_q;
    vec_d   = vec_q;
    oe_d    = oe_q;
    idx_d   = idx_q;
    ack_d   = 4'd0;
    tmo_d   = 1'b0;
    clr     = 4'd0;
    unique case (st_q)
      IDLE: begin
        int_n_d = ~|elig;
        oe_d    = 1'b0;
        vec_d   = 8'd0;
      end
      ASSERT: begin
        if (elig == 4'd0) begin
          int_n_d = 1'b1;
        end else if (inta) begin
          // Winner frozen here; later req/mask changes cannot alter vec
          idx_d      = win;
          clr[win]   = 1'b1;
          int_n_d    = 1'b1;
          vec_d      = {VEC_BASE[7:3], win, 1'b0};
          oe_d       = 1'b1;
        end else if (tmo_hit) begin
          clr[win] = 1'b1;
          tmo_d    = 1'b1;
          int_n_d  = 1'b1;
        end else begin
          int_n_d = 1'b0;
        end
      end
      DRIVE: begin
        int_n_d = 1'b1;
        if (bus.iorq_n) begin
          oe_d         = 1'b0;
          vec_d        = 8'd0;
          ack_d[idx_q] = 1'b1;
        end
      end
      default: begin
        int_n_d = 1'b1;
        oe_d    = 1'b0;
        vec_d   = 8'd0;
      end
    endcase
  end

  // New requests win over a same-cycle clear
  assign pend_d = (pend_q & ~clr) | bus.req;

  assign bus.int_n  = int_n_q;
  assign bus.vec    = vec_q;
  assign bus.vec_oe = oe_q;
  assign bus.ack    = ack_q;
  assign bus.tmo    = tmo_q;

endmodule

// File: tb/tb_zintack.sv
// Scoreboard bench for zintack: directed interrupt scenarios,
// monitor pops expected vector/ack/timeout events.
module tb_zintack;

  logic fclk;
  logic rst;
  logic zpos_en;
  int   ph;
  int   nc;
  int   nf;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t q[$];

  zintack_if bus();

  zintack #(
    .VEC_BASE(8'hF0),
    .TMO_CYC (6'd4)
  ) dut (
    .fclk(fclk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  initial begin
    ph       = 0;
    bus.zpos = 1'b0;
    bus.zneg = 1'b0;
    forever begin
      @(negedge fclk);
      ph       = (ph + 1) % 4;
      bus.zpos = zpos_en && (ph == 0);
      bus.zneg = (ph == 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endfunction

  task automatic pop_chk(input int k, input logic [7:0] v,
                         input string nm);
    ev_t e;
    if (q.size() == 0) begin
      nc++;
      nf++;
      $display("FAIL %s unexpected: got %0h want none", nm, v);
    end else begin
      e = q.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      chk(nm, {24'd0, v}, {24'd0, e.val});
    end
  endtask

  logic       prev_oe;
  logic [7:0] held;

  initial begin
    prev_oe = 1'b0;
    held    = 8'd0;
    forever begin
      @(negedge fclk);
      if (!rst) begin
        if (bus.vec_oe && !prev_oe) begin
          pop_chk(0, bus.vec, "vec");
          held = bus.vec;
        end else if (bus.vec_oe) begin
          chk("vec_hold", {24'd0, bus.vec}, {24'd0, held});
        end else begin
          chk("vec_idle_zero", {24'd0, bus.vec}, 32'd0);
        end
        if (bus.vec_oe)
          chk("intn_hi_drive", {31'd0, bus.int_n}, 32'd1);
        if (bus.ack != 4'd0)
          pop_chk(1, {4'd0, bus.ack}, "ack");
        if (bus.tmo)
          pop_chk(2, 8'd1, "tmo");
      end
      prev_oe = bus.vec_oe;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge fclk);
    #1;
  endtask

  task automatic wait_low(input string nm);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!bus.int_n) break;
    end
    chk(nm, {31'd0, bus.int_n}, 32'd0);
  endtask

  task automatic inta(input logic [3:0] req_same, input int hold);
    tick();
    bus.m1_n = 1'b0;
    tick();
    bus.iorq_n = 1'b0;
    for (int n = 0; n < 8 && !bus.zneg; n++) tick();
    bus.req = req_same;
    tick();
    bus.req = 4'd0;
    chk("oe_after_inta", {31'd0, bus.vec_oe}, 32'd1);
    repeat (hold) tick();
    bus.iorq_n = 1'b1;
    bus.m1_n   = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [3:0] r);
    bus.req = r;
    tick();
    bus.req = 4'd0;
  endtask

  initial begin
    nc         = 0;
    nf         = 0;
    zpos_en    = 1'b0;
    rst        = 1'b1;
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    bus.req    = 4'd0;
    bus.mask   = 4'hF;
    repeat (3) tick();
    chk("rst_int_n", {31'd0, bus.int_n}, 32'd1);
    chk("rst_vec_oe", {31'd0, bus.vec_oe}, 32'd0);
    chk("rst_vec", {24'd0, bus.vec}, 32'd0);
    chk("rst_ack", {28'd0, bus.ack}, 32'd0);
    chk("rst_tmo", {31'd0, bus.tmo}, 32'd0);
    rst = 1'b0;
    tick();

    // single source 2
    push(0, 8'hF4);
    push(1, 8'h04);
    pulse(4'b0100);
    wait_low("t1_int_low");
    inta(4'd0, 3);
    chk("t1_int_hi", {31'd0, bus.int_n}, 32'd1);

    // priority: 3 then 0 before INTA
    push(0, 8'hF0);
    push(1, 8'h01);
    push(0, 8'hF6);
    push(1, 8'h08);
    pulse(4'b1000);
    pulse(4'b0001);
    wait_low("t2_int_low");
    inta(4'd0, 2);
    chk("t2_gap_hi", {31'd0, bus.int_n}, 32'd1);
    wait_low("t2_reassert");
    inta(4'd0, 2);

    // masking while asserted
    pulse(4'b0010);
    wait_low("t3_int_low");
    bus.mask = 4'b1101;
    tick();
    chk("t3_mask_hi", {31'd0, bus.int_n}, 32'd1);
    repeat (5) tick();
    chk("t3_mask_hold", {31'd0, bus.int_n}, 32'd1);
    push(0, 8'hF2);
    push(1, 8'h02);
    bus.mask = 4'hF;
    wait_low("t3_reassert");
    inta(4'd0, 2);

    // req colliding with INTA clear
    push(0, 8'hF4);
    push(1, 8'h04);
    push(0, 8'hF4);
    push(1, 8'h04);
    pulse(4'b0100);
    wait_low("t4_int_low");
    inta(4'b0100, 2);
    wait_low("t4_reassert");
    inta(4'd0, 2);

    // reset during DRIVE
    push(0, 8'hF0);
    pulse(4'b0001);
    wait_low("t5_int_low");
    tick();
    bus.m1_n   = 1'b0;
    bus.iorq_n = 1'b0;
    for (int n = 0; n < 8 && !bus.zneg; n++) tick();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'd0;
    chk("t5_oe", {31'd0, bus.vec_oe}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_oe", {31'd0, bus.vec_oe}, 32'd0);
    chk("t5_rst_intn", {31'd0, bus.int_n}, 32'd1);
    chk("t5_rst_ack", {28'd0, bus.ack}, 32'd0);
    chk("t5_rst_vec", {24'd0, bus.vec}, 32'd0);
    bus.iorq_n = 1'b1;
    bus.m1_n   = 1'b1;
    repeat (3) tick();
    push(0, 8'hF6);
    push(1, 8'h08);
    rst     = 1'b0;
    bus.req = 4'b1000;
    tick();
    bus.req = 4'd0;
    wait_low("t5_post_rst");
    inta(4'd0, 2);

    // timeout
    zpos_en = 1'b1;
`ifdef ZINTACK_TIMEOUT_EN
    push(2, 8'd1);
    pulse(4'b0001);
    wait_low("t6_int_low");
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tmo) break;
    end
    chk("t6_tmo", {31'd0, bus.tmo}, 32'd1);
    chk("t6_intn", {31'd0, bus.int_n}, 32'd1);
    repeat (10) tick();
    chk("t6_pend_clr", {31'd0, bus.int_n}, 32'd1);
`else
    push(0, 8'hF0);
    push(1, 8'h01);
    pulse(4'b0001);
    wait_low("t6_int_low");
    begin
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 160; i++) begin
        tick();
        if (bus.int_n || bus.tmo) bad = 1'b1;
      end
      chk("t6_int_stays_low", {31'd0, bad}, 32'd0);
    end
    inta(4'd0, 2);
`endif
    zpos_en = 1'b0;

    repeat (10) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule

// File: doc/zintack.md
ZINTACK -- requirements
Module: zintack

Interface
REQ-001 SHALL have parameter VEC_BASE, default 8'hF0, IM2 vector base; bits [7:3] used, bits [2:0] ignored.
REQ-002 SHALL have parameter TMO_CYC, default 6'd32, timeout length in zpos strobes; used only under ZINTACK_TIMEOUT_EN.
REQ-003 SHALL have port fclk  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports zpos, zneg  in  1 each  single-fclk strobes at Z80 clock rising and falling edges.
REQ-006 SHALL have ports m1_n, iorq_n  in  1 each  Z80 bus controls, active-low.
REQ-007 SHALL have port req  in  4  interrupt request pulses, one fclk wide per event.
REQ-008 SHALL have port mask  in  4  per-source enable, 1 = enabled.
REQ-009 SHALL have port int_n  out  1  Z80 /INT, registered, active-low.
REQ-010 SHALL have ports vec  out  8  and  vec_oe  out  1  vector byte and its data-bus drive enable.
REQ-011 SHALL have port ack  out  4  one-fclk pulse marking the acknowledged source.
REQ-012 SHALL have port tmo  out  1  one-fclk timeout pulse; constant 0 without ZINTACK_TIMEOUT_EN.

Function
REQ-013 SHALL keep pending[3:0]; req[i]=1 sets pending[i] on the next edge, regardless of mask.
REQ-014 SHALL give set priority when req[i] and clear of pending[i] fall in the same cycle.
REQ-015 SHALL define eligible = pending & mask; winner = lowest-index eligible bit (bit 0 highest priority).
REQ-016 SHALL implement states IDLE, ASSERT, DRIVE.
REQ-017 IDLE: int_n=1, vec_oe=0; on eligible != 0, go to ASSERT and drive int_n=0 from the next cycle.
REQ-018 ASSERT: if eligible becomes 0 (masking), go to IDLE with int_n=1 the next cycle; no ack.
REQ-019 ASSERT: INTA is detected when m1_n=0, iorq_n=0 and zneg=1 in the same cycle.
REQ-020 On INTA: latch idx = current winner; clear pending[idx]; set int_n=1, vec={VEC_BASE[7:3], idx, 1'b0}, vec_oe=1; enter DRIVE; all take effect on the next edge.
REQ-021 DRIVE: hold vec and vec_oe=1 while iorq_n=0; on the first cycle with iorq_n=1, clear vec_oe, pulse ack[idx] for one cycle, and enter IDLE.
REQ-022 The winner SHALL be frozen at INTA; later req or mask changes do not alter vec during DRIVE.
REQ-023 A source requested during DRIVE SHALL stay pending and be asserted from IDLE afterwards.
REQ-024 int_n SHALL be high for at least one fclk between consecutive interrupts.
REQ-025 vec SHALL read 8'h00 whenever vec_oe=0.

Reset
REQ-026 While rst=1: pending=0, state=IDLE, int_n=1, vec=0, vec_oe=0, ack=0, tmo=0, timeout counter=0.
REQ-027 Assertion mid-operation (ASSERT or DRIVE) SHALL abort immediately with no ack pulse.
REQ-028 After deassertion, req pulses are accepted from the first clock edge.

Configuration
REQ-029 Macro ZINTACK_TIMEOUT_EN, when defined, SHALL add a 6-bit counter.
REQ-030 Counter behaviour: cleared on entering ASSERT; incremented on each zpos while in ASSERT.
REQ-031 When the counter reaches TMO_CYC: clear pending[winner], pulse tmo, set int_n=1, go to IDLE.
REQ-032 Without ZINTACK_TIMEOUT_EN: no counter; ASSERT persists until INTA or masking; tmo tied 0.

Verification
REQ-033 req=4'b0100, mask=4'hF, INTA 3 zneg later -> int_n low 1 cycle after req; vec=8'hF4, vec_oe=1; after iorq_n rises, ack=4'b0100 for one cycle.
REQ-034 req=4'b1000 then req=4'b0001 before INTA -> first vec=8'hF0, ack[0]; int_n reasserts after the gap; second vec=8'hF6, ack[3].
REQ-035 pending[1] only, mask goes 4'b1101 in ASSERT -> int_n back high next cycle, no ack; pending[1] retained; mask 4'hF -> reassert.
REQ-036 req[2] pulsed in the same cycle INTA clears pending[2] -> pending[2] remains 1; second interrupt with vec=8'hF4.
REQ-037 rst pulsed during DRIVE -> vec_oe=0, int_n=1, ack=0, pending=0 on the same edge.
REQ-038 With ZINTACK_TIMEOUT_EN, TMO_CYC=4, no INTA -> tmo pulses after the 4th zpos; int_n=1; pending[winner]=0; without the macro, int_n stays low indefinitely.
